star_scan_sequencer: RTL and testbench

STAR_SCAN_SEQUENCER -- requirements
Module: star_scan_sequencer

---
 rtl/star_scan_sequencer.sv | 274 +++++++++++++++++++++++++++
 tb/tb_star_scan_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/star_scan_sequencer.sv
// Purpose : raster-scans a 6x6 frame of 3-bit pixels, launches an external bounding-box
//           measurer on each lit pixel not already inside a stored star box, and keeps up
//           to MAX_STARS boxes for combinational readback.
// Latency : 3 cycles per unlit/masked pixel (ADDR, CHECK, ADVANCE); an empty frame reaches
//           DONE 108 cycles after scan_start. Each measured star adds LAUNCH + wait + STORE.
// Backpressure: none; scan_start is ignored while busy, and the measurer is abandoned
//           (timeout_err) if meas_done does not arrive within TIMEOUT+1 wait cycles.
//
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   scan_start              one-cycle pulse, starts a scan from IDLE or DONE
//   mem_addr / mem_q        frame RAM address (y*6+x) and read data (1-cycle latency)
//   mem_sel                 RAM port owner, 1 while the measurer runs
//   meas_start, meas_x/y    measurer launch pulse and held seed coordinate
//   meas_done, meas_*       measurer completion and resulting box
//   busy, scan_done         status levels
//   star_count, overflow, timeout_err   scan results (flags are sticky per scan)
//   rd_idx, rd_*            combinational readback of one result slot

module star_scan_sequencer #(
    parameter int THRESHOLD = 0,
    parameter int MAX_STARS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       scan_start,
    output logic [5:0] mem_addr,
    input  logic [2:0] mem_q,
    output logic       mem_sel,
    output logic       meas_start,
    output logic [2:0] meas_x,
    output logic [2:0] meas_y,
    input  logic       meas_done,
    input  logic [2:0] meas_top,
    input  logic [2:0] meas_bottom,
    input  logic [2:0] meas_left,
    input  logic [2:0] meas_right,
    output logic       busy,
    output logic       scan_done,
    output logic [2:0] star_count,
    output logic       overflow,
    output logic       timeout_err,
    input  logic [1:0] rd_idx,
    output logic [2:0] rd_top,
    output logic [2:0] rd_bottom,
    output logic [2:0] rd_left,
    output logic [2:0] rd_right
);

    localparam int            CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
    localparam logic [2:0]    THR  = 3'(THRESHOLD);
    localparam logic [2:0]    MAXS = 3'(MAX_STARS);

    typedef enum logic [2:0] {
        IDLE, ADDR, CHECK, LAUNCH, WAIT_MEAS, STORE, ADVANCE, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    x_q, x_d, y_q, y_d;
    logic [5:0]    mem_addr_q, mem_addr_d;
    logic          mem_sel_q, mem_sel_d;
    logic          meas_start_q, meas_start_d;
    logic [2:0]    meas_x_q, meas_x_d, meas_y_q, meas_y_d;
    logic          busy_q, busy_d;
    logic          scan_done_q, scan_done_d;
    logic [2:0]    star_count_q, star_count_d;
    logic          overflow_q, overflow_d;
    logic          timeout_err_q, timeout_err_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Box captured on meas_done, committed to a slot one cycle later in STORE.
    logic [2:0]    lat_top_q, lat_top_d, lat_bot_q, lat_bot_d;
    logic [2:0]    lat_lft_q, lat_lft_d, lat_rgt_q, lat_rgt_d;

    logic [2:0]    slot_top_q [MAX_STARS];
    logic [2:0]    slot_bot_q [MAX_STARS];
    logic [2:0]    slot_lft_q [MAX_STARS];
    logic [2:0]    slot_rgt_q [MAX_STARS];
    logic [2:0]    slot_top_d [MAX_STARS];
    logic [2:0]    slot_bot_d [MAX_STARS];
    logic [2:0]    slot_lft_d [MAX_STARS];
    logic [2:0]    slot_rgt_d [MAX_STARS];

    logic lit;
    logic masked;

    assign lit = (mem_q > THR);

    // Only slots already filled in this scan take part in masking; older contents are stale.
    always_comb begin
        masked = 1'b0;
        for (int i = 0; i < MAX_STARS; i++) begin
            if (i < int'(star_count_q) &&
                x_q >= slot_lft_q[i] && x_q <= slot_rgt_q[i] &&
                y_q >= slot_top_q[i] && y_q <= slot_bot_q[i]) begin
                masked = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        meas_x_d      = meas_x_q;
        meas_y_d      = meas_y_q;
        star_count_d  = star_count_q;
        overflow_d    = overflow_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        lat_top_d     = lat_top_q;
        lat_bot_d     = lat_bot_q;
        lat_lft_d     = lat_lft_q;
        lat_rgt_d     = lat_rgt_q;
        slot_top_d    = slot_top_q;
        slot_bot_d    = slot_bot_q;
        slot_lft_d    = slot_lft_q;
        slot_rgt_d    = slot_rgt_q;

        case (state_q)
            IDLE, DONE: begin
                if (scan_start) begin
                    state_d       = ADDR;
                    x_d           = 3'd0;
                    y_d           = 3'd0;
                    star_count_d  = 3'd0;
                    overflow_d    = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ADDR: state_d = CHECK;
            CHECK: begin
                if (lit && !masked) begin
                    if (star_count_q < MAXS) begin
                        state_d  = LAUNCH;
                        meas_x_d = x_q;
                        meas_y_d = y_q;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = ADVANCE;
                    end
                end else begin
                    state_d = ADVANCE;
                end
            end
            LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = WAIT_MEAS;
            end
            WAIT_MEAS: begin
                // A completion in the same cycle as the timeout still counts.
                if (meas_done) begin
                    lat_top_d = meas_top;
                    lat_bot_d = meas_bottom;
                    lat_lft_d = meas_left;
                    lat_rgt_d = meas_right;
                    state_d   = STORE;
                end else if (wait_cnt_q == TMO) begin
                    timeout_err_d = 1'b1;
                    state_d       = ADVANCE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            STORE: begin
                for (int i = 0; i < MAX_STARS; i++) begin
                    if (int'(star_count_q) == i) begin
                        slot_top_d[i] = lat_top_q;
                        slot_bot_d[i] = lat_bot_q;
                        slot_lft_d[i] = lat_lft_q;
                        slot_rgt_d[i] = lat_rgt_q;
                    end
                end
                star_count_d = star_count_q + 3'd1;
                state_d      = ADVANCE;
            end
            ADVANCE: begin
                if (x_q == 3'd5 && y_q == 3'd5) begin
                    state_d = DONE;
                end else if (x_q == 3'd5) begin
                    x_d     = 3'd0;
                    y_d     = y_q + 3'd1;
                    state_d = ADDR;
                end else begin
                    x_d     = x_q + 3'd1;
                    state_d = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up with it.
        mem_addr_d   = 6'(y_d) * 6'd6 + 6'(x_d);
        mem_sel_d    = (state_d == LAUNCH) || (state_d == WAIT_MEAS) || (state_d == STORE);
        meas_start_d = (state_d == LAUNCH);
        busy_d       = (state_d != IDLE) && (state_d != DONE);
        scan_done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            x_q           <= 3'd0;
            y_q           <= 3'd0;
            mem_addr_q    <= 6'd0;
            mem_sel_q     <= 1'b0;
            meas_start_q  <= 1'b0;
            meas_x_q      <= 3'd0;
            meas_y_q      <= 3'd0;
            busy_q        <= 1'b0;
            scan_done_q   <= 1'b0;
            star_count_q  <= 3'd0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            mem_addr_q    <= mem_addr_d;
            mem_sel_q     <= mem_sel_d;
            meas_start_q  <= meas_start_d;
            meas_x_q      <= meas_x_d;
            meas_y_q      <= meas_y_d;
            busy_q        <= busy_d;
            scan_done_q   <= scan_done_d;
            star_count_q  <= star_count_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Box storage carries no reset: contents only matter below star_count.
    always_ff @(posedge clk) begin
        lat_top_q  <= lat_top_d;
        lat_bot_q  <= lat_bot_d;
        lat_lft_q  <= lat_lft_d;
        lat_rgt_q  <= lat_rgt_d;
        slot_top_q <= slot_top_d;
        slot_bot_q <= slot_bot_d;
        slot_lft_q <= slot_lft_d;
        slot_rgt_q <= slot_rgt_d;
    end

    always_comb begin
        rd_top    = 3'd0;
        rd_bottom = 3'd0;
        rd_left   = 3'd0;
        rd_right  = 3'd0;
        for (int i = 0; i < MAX_STARS; i++) begin
            if (int'(rd_idx) == i) begin
                rd_top    = slot_top_q[i];
                rd_bottom = slot_bot_q[i];
                rd_left   = slot_lft_q[i];
                rd_right  = slot_rgt_q[i];
            end
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_sel     = mem_sel_q;
    assign meas_start  = meas_start_q;
    assign meas_x      = meas_x_q;
    assign meas_y      = meas_y_q;
    assign busy        = busy_q;
    assign scan_done   = scan_done_q;
    assign star_count  = star_count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_star_scan_sequencer.sv
// Directed bench for star_scan_sequencer: frame RAM model, a measurer model with
// selectable behaviour, and hand-computed expectations checked after each step.
module tb_star_scan_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       scan_start = 1'b0;
    logic [5:0] mem_addr;
    logic [2:0] mem_q = 3'd0;
    logic       mem_sel;
    logic       meas_start;
    logic [2:0] meas_x, meas_y;
    logic       meas_done = 1'b0;
    logic [2:0] meas_top = 3'd0, meas_bottom = 3'd0, meas_left = 3'd0, meas_right = 3'd0;
    logic       busy, scan_done;
    logic [2:0] star_count;
    logic       overflow, timeout_err;
    logic [1:0] rd_idx = 2'd0;
    logic [2:0] rd_top, rd_bottom, rd_left, rd_right;

    int checks = 0;
    int failures = 0;

    star_scan_sequencer dut (
        .clk(clk), .resetn(resetn), .scan_start(scan_start),
        .mem_addr(mem_addr), .mem_q(mem_q), .mem_sel(mem_sel),
        .meas_start(meas_start), .meas_x(meas_x), .meas_y(meas_y),
        .meas_done(meas_done), .meas_top(meas_top), .meas_bottom(meas_bottom),
        .meas_left(meas_left), .meas_right(meas_right),
        .busy(busy), .scan_done(scan_done), .star_count(star_count),
        .overflow(overflow), .timeout_err(timeout_err),
        .rd_idx(rd_idx), .rd_top(rd_top), .rd_bottom(rd_bottom),
        .rd_left(rd_left), .rd_right(rd_right)
    );

    always #5 clk = ~clk;

    // Frame RAM: synchronous read, data valid one cycle after the address.
    logic [2:0] frame [0:63];
    always @(posedge clk) mem_q <= frame[mem_addr];

    // Measurer model. resp_mode 0: box = seed pixel; 1: fixed box (1,2,2,3); 2: never answers.
    int         resp_mode = 0;
    logic       stray_done = 1'b0;
    int         pend = 0;
    int         launches = 0;
    int         msel_cnt = 0;
    logic [2:0] seed_x = 3'd0, seed_y = 3'd0;

    always @(negedge clk) begin
        meas_done <= stray_done;
        if (meas_start) begin
            launches <= launches + 1;
            seed_x   <= meas_x;
            seed_y   <= meas_y;
        end
        if (mem_sel) msel_cnt <= msel_cnt + 1;
        if (!resetn) begin
            pend <= 0;
        end else if (meas_start) begin
            pend <= (resp_mode == 2) ? 0 : 3;
        end else if (pend == 1) begin
            pend      <= 0;
            meas_done <= 1'b1;
            if (resp_mode == 1) begin
                meas_top <= 3'd1; meas_bottom <= 3'd2; meas_left <= 3'd2; meas_right <= 3'd3;
            end else begin
                meas_top <= meas_y; meas_bottom <= meas_y; meas_left <= meas_x; meas_right <= meas_x;
            end
        end else if (pend > 1) begin
            pend <= pend - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!scan_done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_reached", 32'(scan_done), 32'd1);
    endtask

    task automatic chk_slot(input string tag, input logic [1:0] idx,
                            input logic [2:0] t, input logic [2:0] b,
                            input logic [2:0] l, input logic [2:0] r);
        rd_idx = idx;
        #1;
        chk({tag, "_top"}, 32'(rd_top), 32'(t));
        chk({tag, "_bot"}, 32'(rd_bottom), 32'(b));
        chk({tag, "_lft"}, 32'(rd_left), 32'(l));
        chk({tag, "_rgt"}, 32'(rd_right), 32'(r));
    endtask

    task automatic load_five();
        for (int i = 0; i < 64; i++) frame[i] = 3'd0;
        frame[0*6+1] = 3'd2;
        frame[0*6+4] = 3'd7;
        frame[2*6+0] = 3'd1;
        frame[3*6+3] = 3'd4;
        frame[5*6+5] = 3'd3;
    endtask

    int cyc;
    int l0, m0;

    initial begin
        for (int i = 0; i < 64; i++) frame[i] = 3'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(scan_done), 32'd0);
        chk("rst_count", 32'(star_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_msel", 32'(mem_sel), 32'd0);
        chk("rst_mstart", 32'(meas_start), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Empty frame, with meas_done held high outside any measurement: 108 cycles, no launch
        l0 = launches; m0 = msel_cnt;
        stray_done = 1'b1;
        pulse_start();
        chk("empty_busy", 32'(busy), 32'd1);
        chk("empty_addr0", 32'(mem_addr), 32'd0);
        repeat (107) @(posedge clk);
        #1;
        chk("empty_done_107", 32'(scan_done), 32'd0);
        @(posedge clk);
        #1;
        chk("empty_done_108", 32'(scan_done), 32'd1);
        chk("empty_busy_end", 32'(busy), 32'd0);
        chk("empty_count", 32'(star_count), 32'd0);
        chk("empty_launches", 32'(launches - l0), 32'd0);
        chk("empty_msel", 32'(msel_cnt - m0), 32'd0);
        stray_done = 1'b0;

        // One 2x2 block at x2..3, y1..2; measurer reports (1,2,2,3)
        frame[1*6+2] = 3'd3; frame[1*6+3] = 3'd3;
        frame[2*6+2] = 3'd3; frame[2*6+3] = 3'd3;
        resp_mode = 1;
        l0 = launches;
        pulse_start();
        wait_done(cyc);
        chk("blk_cycles", 32'(cyc), 32'd113);
        chk("blk_launches", 32'(launches - l0), 32'd1);
        chk("blk_seed_x", 32'(seed_x), 32'd2);
        chk("blk_seed_y", 32'(seed_y), 32'd1);
        chk("blk_count", 32'(star_count), 32'd1);
        chk_slot("blk_s0", 2'd0, 3'd1, 3'd2, 3'd2, 3'd3);

        // Five isolated pixels: four stored in raster order, fifth overflows
        load_five();
        resp_mode = 0;
        l0 = launches;
        pulse_start();
        wait_done(cyc);
        chk("five_cycles", 32'(cyc), 32'd128);
        chk("five_launches", 32'(launches - l0), 32'd4);
        chk("five_count", 32'(star_count), 32'd4);
        chk("five_ovf", 32'(overflow), 32'd1);
        chk_slot("five_s0", 2'd0, 3'd0, 3'd0, 3'd1, 3'd1);
        chk_slot("five_s1", 2'd1, 3'd0, 3'd0, 3'd4, 3'd4);
        chk_slot("five_s2", 2'd2, 3'd2, 3'd2, 3'd0, 3'd0);
        repeat (5) @(posedge clk);
        chk_slot("five_s3", 2'd3, 3'd3, 3'd3, 3'd3, 3'd3);

        // Measurer silent: timeout after 256 wait cycles, scan still completes
        for (int i = 0; i < 64; i++) frame[i] = 3'd0;
        frame[0] = 3'd1;
        resp_mode = 2;
        pulse_start();
        chk("tmo_ovf_cleared", 32'(overflow), 32'd0);
        chk("tmo_count_cleared", 32'(star_count), 32'd0);
        repeat (258) @(posedge clk);
        #1;
        chk("tmo_not_yet", 32'(timeout_err), 32'd0);
        chk("tmo_msel_wait", 32'(mem_sel), 32'd1);
        @(posedge clk);
        #1;
        chk("tmo_set", 32'(timeout_err), 32'd1);
        chk("tmo_msel_adv", 32'(mem_sel), 32'd0);
        wait_done(cyc);
        chk("tmo_count", 32'(star_count), 32'd0);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);

        // Reset during WAIT_MEAS, then a clean rescan from (0,0)
        pulse_start();
        repeat (10) @(posedge clk);
        #1;
        chk("rw_in_wait", 32'(mem_sel), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_msel", 32'(mem_sel), 32'd0);
        chk("rw_count", 32'(star_count), 32'd0);
        chk("rw_tmo", 32'(timeout_err), 32'd0);
        chk("rw_addr", 32'(mem_addr), 32'd0);
        chk("rw_done", 32'(scan_done), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        resp_mode = 0;
        l0 = launches;
        pulse_start();
        wait_done(cyc);
        chk("rw_cycles", 32'(cyc), 32'd113);
        chk("rw_launches", 32'(launches - l0), 32'd1);
        chk("rw_seed_x", 32'(seed_x), 32'd0);
        chk("rw_seed_y", 32'(seed_y), 32'd0);
        chk("rw_count2", 32'(star_count), 32'd1);
        chk_slot("rw_s0", 2'd0, 3'd0, 3'd0, 3'd0, 3'd0);

        // scan_start pulses while busy must not disturb the five-pixel scan
        load_five();
        l0 = launches;
        pulse_start();
        repeat (20) @(posedge clk);
        pulse_start();
        repeat (50) @(posedge clk);
        pulse_start();
        wait_done(cyc);
        chk("busy_cycles", 32'(cyc + 72), 32'd128);
        chk("busy_launches", 32'(launches - l0), 32'd4);
        chk("busy_count", 32'(star_count), 32'd4);
        chk("busy_ovf", 32'(overflow), 32'd1);
        chk_slot("busy_s0", 2'd0, 3'd0, 3'd0, 3'd1, 3'd1);
        chk_slot("busy_s3", 2'd3, 3'd3, 3'd3, 3'd3, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
